bin2bcd_seq_conv: RTL and testbench

- Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It is the successor of the fixed 8-bit, 3-digit switch decoder.
- Adds configurable width and digit count, signed (two's-complement) input, an explicit start/busy/done handshake, an auto-convert-on-change mode, and overflow detection.
- Sits between switch/operand registers and the 7-segment display multiplexer.

---
 rtl/bin2bcd_seq_conv.sv | 141 ++++++++++++++
 tb/tb_bin2bcd_seq_conv.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_conv.sv
// rtl/bin2bcd_seq_conv.sv - parametrised sequential double-dabble binary-to-BCD converter
module bin2bcd_seq_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0,
    parameter int AUTO   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                neg_out,
    output logic                overflow
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] BIN_ONE   = WIDTH'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    scratch_q, scratch_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic             sign_q, sign_d;
    logic             acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic [SW-1:0]    adj;
    logic [SW-1:0]    shifted;
    logic [WIDTH-1:0] mag;
    logic             is_neg;
    logic             trigger;

    // Add-3 correction on every BCD nibble, then the one-bit shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[WIDTH+4*i +: 4] = adj[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[SW-2:0], 1'b0};
    end

    always_comb begin
        is_neg  = (SIGNED != 0) && bin_in[WIDTH-1];
        mag     = is_neg ? (~bin_in + BIN_ONE) : bin_in;
        trigger = start || ((AUTO != 0) && (!valid_q || (bin_in != last_q)));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        last_d    = last_q;
        valid_d   = valid_q;
        sign_d    = sign_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    last_d    = bin_in;
                    valid_d   = 1'b1;
                    sign_d    = is_neg;
                    scratch_d = {{BW{1'b0}}, mag};
                    cnt_d     = '0;
                    acc_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q + CNT_ONE;
                acc_d     = acc_q | adj[SW-1];
                if (cnt_q == LAST_ITER) begin
                    bcd_d   = shifted[SW-1:WIDTH];
                    neg_d   = sign_q;
                    ovf_d   = acc_q | adj[SW-1];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scratch_q <= '0;
            last_q    <= '0;
            valid_q   <= 1'b0;
            sign_q    <= 1'b0;
            acc_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            sign_q    <= sign_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign neg_out  = neg_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq_conv.sv
// tb/tb_bin2bcd_seq_conv.sv - directed-vector bench for bin2bcd_seq_conv across parameter sets
module tb_bin2bcd_seq_conv;
    logic clk;
    logic rst_n;
    logic start8, start16, start_a;
    logic [7:0]  bin8, bin_a;
    logic [15:0] bin16;

    logic busy0, done0, neg0, ovf0;
    logic [11:0] bcd0;
    logic busy1, done1, neg1, ovf1;
    logic [11:0] bcd1;
    logic busy3, done3, neg3, ovf3;
    logic [7:0]  bcd3;
    logic busy_a, done_a, neg_a, ovf_a;
    logic [11:0] bcd_a;
    logic busy4, done4, neg4, ovf4;
    logic [19:0] bcd4;
    logic busy5, done5, neg5, ovf5;
    logic [19:0] bcd5;

    int n_cmp = 0;
    int n_bad = 0;

    bin2bcd_seq_conv #(.WIDTH(8), .DIGITS(3), .SIGNED(0), .AUTO(0)) u_u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8), .busy(busy0),
        .done(done0), .bcd_out(bcd0), .neg_out(neg0), .overflow(ovf0));
    bin2bcd_seq_conv #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .AUTO(0)) u_s8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8), .busy(busy1),
        .done(done1), .bcd_out(bcd1), .neg_out(neg1), .overflow(ovf1));
    bin2bcd_seq_conv #(.WIDTH(8), .DIGITS(2), .SIGNED(0), .AUTO(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8), .busy(busy3),
        .done(done3), .bcd_out(bcd3), .neg_out(neg3), .overflow(ovf3));
    bin2bcd_seq_conv #(.WIDTH(8), .DIGITS(3), .SIGNED(0), .AUTO(1)) u_auto (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a), .busy(busy_a),
        .done(done_a), .bcd_out(bcd_a), .neg_out(neg_a), .overflow(ovf_a));
    bin2bcd_seq_conv #(.WIDTH(16), .DIGITS(5), .SIGNED(0), .AUTO(0)) u_u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .bin_in(bin16), .busy(busy4),
        .done(done4), .bcd_out(bcd4), .neg_out(neg4), .overflow(ovf4));
    bin2bcd_seq_conv #(.WIDTH(16), .DIGITS(5), .SIGNED(1), .AUTO(0)) u_s16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .bin_in(bin16), .busy(busy5),
        .done(done5), .bcd_out(bcd5), .neg_out(neg5), .overflow(ovf5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run8(input logic [7:0] v, input logic [11:0] e_u, input logic [11:0] e_s,
                        input logic e_sn, input logic [7:0] e_d2, input logic e_d2o);
        int nb, nd;
        @(negedge clk);
        bin8 = v;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            nb += int'(busy0);
            nd += int'(done0);
            @(posedge clk); #1;
        end
        check_eq("w8_busy_cycles", 32'(nb), 32'd8);
        check_eq("w8_early_done", 32'(nd), 32'd0);
        check_eq("w8_done", 32'(done0), 32'd1);
        check_eq("w8_busy_end", 32'(busy0), 32'd0);
        check_eq("w8_bcd", 32'(bcd0), 32'(e_u));
        check_eq("w8_ovf", 32'(ovf0), 32'd0);
        check_eq("w8_neg", 32'(neg0), 32'd0);
        check_eq("s8_done", 32'(done1), 32'd1);
        check_eq("s8_bcd", 32'(bcd1), 32'(e_s));
        check_eq("s8_neg", 32'(neg1), 32'(e_sn));
        check_eq("s8_ovf", 32'(ovf1), 32'd0);
        check_eq("d2_done", 32'(done3), 32'd1);
        check_eq("d2_bcd", 32'(bcd3), 32'(e_d2));
        check_eq("d2_ovf", 32'(ovf3), 32'(e_d2o));
    endtask

    task automatic run16(input logic [15:0] v, input logic [19:0] e_u, input logic [19:0] e_s,
                         input logic e_sn);
        int nb;
        @(negedge clk);
        bin16 = v;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            nb += int'(busy4) + int'(done4);
            @(posedge clk); #1;
        end
        check_eq("w16_busy_cycles", 32'(nb), 32'd16);
        check_eq("w16_done", 32'(done4), 32'd1);
        check_eq("w16_bcd", 32'(bcd4), 32'(e_u));
        check_eq("w16_ovf", 32'(ovf4), 32'd0);
        check_eq("s16_done", 32'(done5), 32'd1);
        check_eq("s16_bcd", 32'(bcd5), 32'(e_s));
        check_eq("s16_neg", 32'(neg5), 32'(e_sn));
    endtask

    initial begin
        int cyc, nd;
        rst_n = 1'b0;
        start8 = 1'b0;
        start16 = 1'b0;
        start_a = 1'b0;
        bin8 = 8'd0;
        bin16 = 16'd0;
        bin_a = 8'd42;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_done", 32'(done0), 32'd0);
        check_eq("rst_bcd", 32'(bcd0), 32'd0);
        check_eq("rst_neg", 32'(neg0), 32'd0);
        check_eq("rst_ovf", 32'(ovf0), 32'd0);
        check_eq("rst_auto_busy", 32'(busy_a), 32'd0);

        // Auto mode: first conversion starts on release; input changes mid-conversion.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("auto_busy", 32'(busy_a), 32'd1);
        bin_a = 8'd200;
        cyc = 3;
        while (!done_a && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("auto_latency1", 32'(cyc), 32'd9);
        check_eq("auto_bcd1", 32'(bcd_a), 32'h042);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done_a && cyc < 40);
        check_eq("auto_latency2", 32'(cyc), 32'd9);
        check_eq("auto_bcd2", 32'(bcd_a), 32'h200);
        nd = 0;
        repeat (50) begin
            @(posedge clk); #1;
            nd += int'(done_a);
        end
        check_eq("auto_hold_no_done", 32'(nd), 32'd0);
        check_eq("auto_hold_bcd", 32'(bcd_a), 32'h200);

        run8(8'd255, 12'h255, 12'h001, 1'b1, 8'h55, 1'b1);
        run8(8'd0,   12'h000, 12'h000, 1'b0, 8'h00, 1'b0);
        run8(8'd99,  12'h099, 12'h099, 1'b0, 8'h99, 1'b0);
        run8(8'h80,  12'h128, 12'h128, 1'b1, 8'h28, 1'b1);
        run8(8'h7F,  12'h127, 12'h127, 1'b0, 8'h27, 1'b1);
        run8(8'd150, 12'h150, 12'h106, 1'b1, 8'h50, 1'b1);

        run16(16'hFFFF, 20'h65535, 20'h00001, 1'b1);
        run16(16'h8000, 20'h32768, 20'h32768, 1'b1);
        run16(16'h3039, 20'h12345, 20'h12345, 1'b0);
        check_eq("w8_hold_bcd", 32'(bcd0), 32'h150);

        // Asynchronous reset in the third SHIFT cycle.
        @(negedge clk);
        bin8 = 8'd255;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check_eq("abort_busy_before", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy0), 32'd0);
        check_eq("abort_done", 32'(done0), 32'd0);
        check_eq("abort_bcd", 32'(bcd0), 32'd0);
        check_eq("abort_s8_bcd", 32'(bcd1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(posedge clk); #1;
            nd += int'(done0) + int'(busy0);
        end
        check_eq("abort_no_done", 32'(nd), 32'd0);
        check_eq("abort_bcd_after", 32'(bcd0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
